accion_scheduler: RTL and testbench
===================================

Name: accion_scheduler

Overview:
- Sequences the debounced user and sensor events of the virtual-pet design into a single serialized action stream for the pet core.
- Each debounced source is turned into a falling-edge (release) event and latched as a pending request.
- Pending requests are arbitrated by fixed priority and issued one at a time over a valid/ready handshake.
- A cooldown after each issued action rate-limits the pet core; test mode shortens it.

Parameters:
- COOLDOWN_CYC, 25000000, idle cycles after an accepted or aborted action in normal mode (0.5 s at 50 MHz).
- COOLDOWN_TEST_CYC, 2500000, cooldown cycles while test_activo=1.
- ACK_TIMEOUT, 1023, maximum cycles accion_valid is held without accion_ready before the issue is aborted.
- CNT_W, 25, width of the cooldown/timeout counter; must hold max(COOLDOWN_CYC, COOLDOWN_TEST_CYC, ACK_TIMEOUT).

Ports:
- clk  input  1  system clock.
- reset_tmp  input  1  reset, asynchronous, active-low.
- test_activo  input  1  level; test mode enabled (long-press toggle).
- ev_medicina  input  1  debounced medicine button level.
- ev_energia  input  1  debounced energy button level.
- ev_fot  input  1  debounced photocell level.
- ev_ult  input  1  debounced ultrasonic level.
- ev_test  input  1  debounced short-press test level.
- accion_ready  input  1  pet core accepts the action.
- accion_valid  output  1  action presented.
- accion_id  output  3  action code: 0 none, 1 medicina, 2 energia, 3 fot, 4 ult, 5 test.
- pendiente  output  5  pending bits {test, ult, fot, energia, medicina}.
- ocupado  output  1  FSM not in IDLE.
- perdidos  output  8  saturating count of events lost because the source was already pending.

Behaviour:
- Reset (reset_tmp=0, asynchronous): all outputs 0; edge-history registers 0; FSM=IDLE; counter 0. Because history resets to 0, a source already low at reset release generates no event.
- Edge detect, per source:
  - prev <= ev each clock.
  - Event = prev & ~ev (falling edge = button release).
  - On an event the pending bit is set at the same clock edge.
- Lost event: an event on a source whose pending bit is already 1, and which is not being cleared that cycle, increments perdidos. perdidos saturates at 255.
- Set/clear collision: if an event arrives in the same cycle its pending bit is cleared by a handshake, set wins. The bit stays 1 and perdidos does not increment.
- Priority, highest first: medicina > energia > fot > ult > test.
- FSM states and transitions:
  - IDLE: if pendiente != 0, register the winner's id into accion_id and load counter=ACK_TIMEOUT; go to ISSUE. Else accion_id=0.
  - ISSUE: accion_valid=1; accion_id is held stable and is not re-arbitrated even if a higher-priority request arrives.
    - If accion_ready=1: clear that pending bit, drop valid, load counter (see cooldown rule), go to COOLDOWN.
    - Else if counter==0: abort; the pending bit stays set; drop valid; load counter; go to COOLDOWN.
    - Else counter decrements.
  - COOLDOWN: accion_valid=0, accion_id=0. Counter decrements. When counter==0, go to IDLE on the next edge.
- Cooldown load value: COOLDOWN_TEST_CYC if test_activo=1 at the load cycle, else COOLDOWN_CYC. Changes to test_activo during COOLDOWN do not affect the running count.
- Latency:
  - Release sampled at edge k → pendiente bit set after k.
  - accion_valid=1 after edge k+1, provided the FSM was in IDLE.
  - accion_valid falls after the edge where valid&ready is sampled.
- Counter behaviour: a COOLDOWN loaded with N stays in COOLDOWN N+1 cycles. N=0 returns to IDLE after 1 cycle.
- ocupado=1 in ISSUE and COOLDOWN.
- Reset mid-ISSUE: valid drops immediately and asynchronously; all pending requests are discarded.
- Events continue to latch in every state.

Decomposition:
- Shared package accion_pkg:
  - action id constants ACC_NONE..ACC_TEST (3 bits).
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, COOLDOWN=2'd2).
  - priority-order constant.
- One sub-module, evento_latch: edge history, pending bit, set-wins-over-clear, lost-event strobe. It is instantiated 5×.
- Top level holds the arbiter, FSM, shared counter and perdidos.

Test Plan (COOLDOWN_CYC=20, COOLDOWN_TEST_CYC=4, ACK_TIMEOUT=8):
- Single release: ev_energia 1→0 at edge 10, accion_ready tied 1 → accion_valid=1 with id=2 after edge 11; valid=0 after edge 12; ocupado=1 for 21 further cycles; pendiente=0.
- Simultaneous releases: ev_medicina, ev_fot and ev_test all fall on the same edge, ready=1 → ids issued in order 1, 3, 5, each separated by 21 cooldown cycles; perdidos=0.
- Backpressure: accion_ready held 0 → valid held with id stable for 9 cycles, then abort; the pending bit remains 1. After cooldown the same id is reissued; raising ready then completes it.
- Lost event: ev_ult toggles twice during one cooldown → perdidos=1, pendiente[3]=1, exactly one ult action issued. A third release in the same cycle as that action's accept → bit stays 1 and perdidos stays 1.
- Test mode: test_activo=1 at accept → cooldown lasts 5 cycles. Setting test_activo=0 mid-cooldown leaves the count unchanged.
- Reset: reset_tmp pulsed low during ISSUE → accion_valid, pendiente, perdidos and ocupado all 0 immediately. A source held low through reset release produces no action.

Source files
------------

// File: rtl/accion_pkg.sv
// accion_pkg: shared definitions for the action scheduler.
//   - Action codes presented on accion_id (3 bits).
//   - FSM state encoding.
//   - Arbitration order, highest priority first.
//   - ganador(): picks the highest-priority pending request.
package accion_pkg;

    localparam logic [2:0] ACC_NONE     = 3'd0;
    localparam logic [2:0] ACC_MEDICINA = 3'd1;
    localparam logic [2:0] ACC_ENERGIA  = 3'd2;
    localparam logic [2:0] ACC_FOT      = 3'd3;
    localparam logic [2:0] ACC_ULT      = 3'd4;
    localparam logic [2:0] ACC_TEST     = 3'd5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam int N_SRC = 5;

    // Slot 0 (LSBs) is the highest priority; pending bit of id k is bit k-1.
    localparam logic [14:0] PRIO_ORDER = {ACC_TEST, ACC_ULT, ACC_FOT, ACC_ENERGIA, ACC_MEDICINA};

    // Walk from lowest to highest priority so the last match (highest) wins.
    function automatic logic [2:0] ganador(input logic [4:0] pend);
        logic [2:0] id;
        logic [2:0] cand;
        id = ACC_NONE;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            cand = PRIO_ORDER[3*i +: 3];
            if (pend[cand - 3'd1]) begin
                id = cand;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/accion_scheduler_evento_latch.sv
// evento_latch: release detector and pending-request bit for one source.
//   clk_i        system clock
//   reset_tmp_i  asynchronous active-low reset
//   ev_i         debounced source level
//   clr_i        clear request from an accepted handshake
//   pend_o       pending request bit
//   perdido_o    one-cycle strobe: a release was lost because the bit was
//                already pending and not being cleared this cycle
module evento_latch (
    input  logic clk_i,
    input  logic reset_tmp_i,
    input  logic ev_i,
    input  logic clr_i,
    output logic pend_o,
    output logic perdido_o
);

    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic evento;

    // History resets to 0, so a source already low at reset release is silent.
    assign evento = prev_q & ~ev_i;

    // A new release beats a simultaneous clear: the request stays pending.
    always_comb begin
        pend_d = pend_q;
        if (evento) begin
            pend_d = 1'b1;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_tmp_i) begin
        if (!reset_tmp_i) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= ev_i;
            pend_q <= pend_d;
        end
    end

    assign pend_o    = pend_q;
    assign perdido_o = evento & pend_q & ~clr_i;

endmodule

// File: rtl/accion_scheduler.sv
// accion_scheduler: serializes released user/sensor events into one action
// stream for the pet core, with fixed priority, an ack timeout and a
// cooldown after every issued (accepted or aborted) action.
//   clk, reset_tmp (async active-low), test_activo (short cooldown)
//   ev_medicina/ev_energia/ev_fot/ev_ult/ev_test: debounced source levels
//   accion_ready / accion_valid / accion_id: action handshake
//   pendiente: {test, ult, fot, energia, medicina} pending bits
//   ocupado: FSM busy; perdidos: saturating lost-event count
module accion_scheduler
    import accion_pkg::*;
#(
    parameter int COOLDOWN_CYC      = 25000000,
    parameter int COOLDOWN_TEST_CYC = 2500000,
    parameter int ACK_TIMEOUT       = 1023,
    parameter int CNT_W             = 25
) (
    input  logic       clk,
    input  logic       reset_tmp,
    input  logic       test_activo,
    input  logic       ev_medicina,
    input  logic       ev_energia,
    input  logic       ev_fot,
    input  logic       ev_ult,
    input  logic       ev_test,
    input  logic       accion_ready,
    output logic       accion_valid,
    output logic [2:0] accion_id,
    output logic [4:0] pendiente,
    output logic       ocupado,
    output logic [7:0] perdidos
);

    logic [4:0]       ev_vec;
    logic [4:0]       clr_vec;
    logic [4:0]       lost_vec;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       id_q, id_d;
    logic [7:0]       perdidos_q, perdidos_d;
    logic [CNT_W-1:0] cool_load;
    logic [2:0]       n_lost;
    logic [8:0]       suma;

    assign ev_vec = {ev_test, ev_ult, ev_fot, ev_energia, ev_medicina};

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        evento_latch u_latch (
            .clk_i       (clk),
            .reset_tmp_i (reset_tmp),
            .ev_i        (ev_vec[gi]),
            .clr_i       (clr_vec[gi]),
            .pend_o      (pendiente[gi]),
            .perdido_o   (lost_vec[gi])
        );
    end

    // Sampled only at the load cycle; later test_activo changes are ignored.
    assign cool_load = test_activo ? CNT_W'(COOLDOWN_TEST_CYC) : CNT_W'(COOLDOWN_CYC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        clr_vec = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pendiente) begin
                    id_d    = ganador(pendiente);
                    cnt_d   = CNT_W'(ACK_TIMEOUT);
                    state_d = ST_ISSUE;
                end else begin
                    id_d = ACC_NONE;
                end
            end
            ST_ISSUE: begin
                if (accion_ready) begin
                    clr_vec = 5'b00001 << (id_q - 3'd1);
                    cnt_d   = cool_load;
                    id_d    = ACC_NONE;
                    state_d = ST_COOLDOWN;
                end else if (cnt_q == '0) begin
                    // Abort: request stays pending and is retried later.
                    cnt_d   = cool_load;
                    id_d    = ACC_NONE;
                    state_d = ST_COOLDOWN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = ACC_NONE;
            end
        endcase
    end

    // Several sources may lose an event in the same cycle.
    always_comb begin
        n_lost = '0;
        for (int i = 0; i < N_SRC; i++) begin
            n_lost = n_lost + {2'b00, lost_vec[i]};
        end
        suma       = {1'b0, perdidos_q} + {6'b0, n_lost};
        perdidos_d = suma[8] ? 8'hFF : suma[7:0];
    end

    always_ff @(posedge clk or negedge reset_tmp) begin
        if (!reset_tmp) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            id_q       <= ACC_NONE;
            perdidos_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            perdidos_q <= perdidos_d;
        end
    end

    assign accion_valid = (state_q == ST_ISSUE);
    assign accion_id    = (state_q == ST_ISSUE) ? id_q : ACC_NONE;
    assign ocupado      = (state_q != ST_IDLE);
    assign perdidos     = perdidos_q;

endmodule

// File: tb/tb_accion_scheduler.sv
// Directed bench for accion_scheduler with short cooldowns (20 / 4) and an
// ack timeout of 8. Inputs change 1 ns after a rising edge; outputs are
// sampled at that same point.
module tb_accion_scheduler;

    logic       clk = 1'b0;
    logic       reset_tmp;
    logic       test_activo;
    logic       ev_medicina, ev_energia, ev_fot, ev_ult, ev_test;
    logic       accion_ready;
    logic       accion_valid;
    logic [2:0] accion_id;
    logic [4:0] pendiente;
    logic       ocupado;
    logic [7:0] perdidos;

    int checks = 0;
    int errors = 0;
    int w;
    logic seen;

    always #5 clk = ~clk;

    accion_scheduler #(
        .COOLDOWN_CYC      (20),
        .COOLDOWN_TEST_CYC (4),
        .ACK_TIMEOUT       (8),
        .CNT_W             (25)
    ) dut (
        .clk          (clk),
        .reset_tmp    (reset_tmp),
        .test_activo  (test_activo),
        .ev_medicina  (ev_medicina),
        .ev_energia   (ev_energia),
        .ev_fot       (ev_fot),
        .ev_ult       (ev_ult),
        .ev_test      (ev_test),
        .accion_ready (accion_ready),
        .accion_valid (accion_valid),
        .accion_id    (accion_id),
        .pendiente    (pendiente),
        .ocupado      (ocupado),
        .perdidos     (perdidos)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (accion_valid !== 1'b1 && waited < budget) begin
            step();
            waited++;
        end
        chk("valid_seen", {31'b0, accion_valid}, 32'd1);
    endtask

    initial begin
        reset_tmp    = 1'b0;
        test_activo  = 1'b0;
        ev_medicina  = 1'b1;
        ev_energia   = 1'b1;
        ev_fot       = 1'b1;
        ev_ult       = 1'b1;
        ev_test      = 1'b1;
        accion_ready = 1'b0;
        #1;
        chk("rst_valid", {31'b0, accion_valid}, 32'd0);
        chk("rst_id", {29'b0, accion_id}, 32'd0);
        chk("rst_pend", {27'b0, pendiente}, 32'd0);
        chk("rst_ocupado", {31'b0, ocupado}, 32'd0);
        chk("rst_perdidos", {24'b0, perdidos}, 32'd0);
        repeat (3) step();
        reset_tmp = 1'b1;
        repeat (3) step();
        chk("idle_pend", {27'b0, pendiente}, 32'd0);
        chk("idle_ocupado", {31'b0, ocupado}, 32'd0);

        // Single release, ready tied high.
        accion_ready = 1'b1;
        ev_energia = 1'b0;
        step();
        chk("t1_pend_set", {27'b0, pendiente}, 32'b00010);
        chk("t1_valid_low", {31'b0, accion_valid}, 32'd0);
        step();
        chk("t1_valid", {31'b0, accion_valid}, 32'd1);
        chk("t1_id", {29'b0, accion_id}, 32'd2);
        chk("t1_ocupado", {31'b0, ocupado}, 32'd1);
        step();
        chk("t1_valid_drop", {31'b0, accion_valid}, 32'd0);
        chk("t1_id_drop", {29'b0, accion_id}, 32'd0);
        chk("t1_pend_clr", {27'b0, pendiente}, 32'd0);
        chk("t1_cool_first", {31'b0, ocupado}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t1_cool", {31'b0, ocupado}, 32'd1);
        end
        step();
        chk("t1_cool_done", {31'b0, ocupado}, 32'd0);

        // Simultaneous releases: medicina, fot, test.
        ev_medicina = 1'b0;
        ev_fot      = 1'b0;
        ev_test     = 1'b0;
        step();
        chk("t2_pend", {27'b0, pendiente}, 32'b10101);
        wait_valid(5, w);
        chk("t2_id1", {29'b0, accion_id}, 32'd1);
        chk("t2_lat1", w, 32'd1);
        step();
        chk("t2_pend_after1", {27'b0, pendiente}, 32'b10100);
        wait_valid(40, w);
        chk("t2_id3", {29'b0, accion_id}, 32'd3);
        chk("t2_gap3", w, 32'd22);
        step();
        wait_valid(40, w);
        chk("t2_id5", {29'b0, accion_id}, 32'd5);
        chk("t2_gap5", w, 32'd22);
        step();
        chk("t2_pend_empty", {27'b0, pendiente}, 32'd0);
        chk("t2_perdidos", {24'b0, perdidos}, 32'd0);

        // Backpressure: timeout after 9 valid cycles, then reissue.
        accion_ready = 1'b0;
        ev_fot = 1'b1;
        step();
        ev_fot = 1'b0;
        step();
        chk("t3_pend", {27'b0, pendiente}, 32'b00100);
        wait_valid(40, w);
        chk("t3_id", {29'b0, accion_id}, 32'd3);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_hold_valid", {31'b0, accion_valid}, 32'd1);
            chk("t3_hold_id", {29'b0, accion_id}, 32'd3);
        end
        step();
        chk("t3_abort_valid", {31'b0, accion_valid}, 32'd0);
        chk("t3_abort_pend", {27'b0, pendiente}, 32'b00100);
        chk("t3_abort_ocupado", {31'b0, ocupado}, 32'd1);
        wait_valid(40, w);
        chk("t3_reissue_id", {29'b0, accion_id}, 32'd3);
        chk("t3_reissue_gap", w, 32'd22);
        accion_ready = 1'b1;
        step();
        chk("t3_done_valid", {31'b0, accion_valid}, 32'd0);
        chk("t3_done_pend", {27'b0, pendiente}, 32'd0);

        // Lost event during cooldown, then set-wins collision.
        ev_ult = 1'b0;
        step();
        ev_ult = 1'b1;
        step();
        ev_ult = 1'b0;
        step();
        chk("t4_perdidos", {24'b0, perdidos}, 32'd1);
        chk("t4_pend", {27'b0, pendiente}, 32'b01000);
        chk("t4_in_cool", {31'b0, ocupado}, 32'd1);
        accion_ready = 1'b0;
        wait_valid(40, w);
        chk("t4_id", {29'b0, accion_id}, 32'd4);
        ev_ult = 1'b1;
        step();
        ev_ult = 1'b0;
        accion_ready = 1'b1;
        step();
        chk("t4_collide_pend", {27'b0, pendiente}, 32'b01000);
        chk("t4_collide_perdidos", {24'b0, perdidos}, 32'd1);
        chk("t4_collide_valid", {31'b0, accion_valid}, 32'd0);

        // Test-mode cooldown: 4 -> 5 busy cycles, unaffected by later change.
        test_activo = 1'b1;
        wait_valid(40, w);
        chk("t5_id", {29'b0, accion_id}, 32'd4);
        chk("t5_gap", w, 32'd22);
        step();
        chk("t5_cool_first", {31'b0, ocupado}, 32'd1);
        chk("t5_pend", {27'b0, pendiente}, 32'd0);
        test_activo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_cool", {31'b0, ocupado}, 32'd1);
        end
        step();
        chk("t5_cool_done", {31'b0, ocupado}, 32'd0);

        // Asynchronous reset in the middle of ISSUE.
        accion_ready = 1'b0;
        ev_medicina = 1'b1;
        step();
        ev_medicina = 1'b0;
        step();
        wait_valid(10, w);
        chk("t6_id", {29'b0, accion_id}, 32'd1);
        chk("t6_perdidos_pre", {24'b0, perdidos}, 32'd1);
        ev_fot = 1'b1;
        step();
        ev_fot = 1'b0;
        step();
        chk("t6_pend_pre", {27'b0, pendiente}, 32'b00101);
        #2;
        reset_tmp   = 1'b0;
        ev_medicina = 1'b0;
        ev_energia  = 1'b0;
        ev_fot      = 1'b0;
        ev_ult      = 1'b0;
        ev_test     = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, accion_valid}, 32'd0);
        chk("t6_rst_id", {29'b0, accion_id}, 32'd0);
        chk("t6_rst_pend", {27'b0, pendiente}, 32'd0);
        chk("t6_rst_perdidos", {24'b0, perdidos}, 32'd0);
        chk("t6_rst_ocupado", {31'b0, ocupado}, 32'd0);
        repeat (2) step();
        reset_tmp = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | accion_valid | (|pendiente);
        end
        chk("t6_no_event_low_src", {31'b0, seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
